// File: rtl/nf10_ipif_arbiter_if.sv
// nf10_ipif_arbiter_if: single IPIF register-port bundle.
// master = arbiter side, slave = register/ROM side.
interface nf10_ipif_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 32
) ();
   logic            Bus2IP_CS;
   logic            Bus2IP_RNW;
   logic [AW-1:0]   Bus2IP_Addr;
   logic [DW-1:0]   Bus2IP_Data;
   logic [DW/8-1:0] Bus2IP_BE;
   logic [DW-1:0]   IP2Bus_Data;
   logic            IP2Bus_RdAck;
   logic            IP2Bus_WrAck;
   logic            IP2Bus_Error;

   modport master (
      output Bus2IP_CS, Bus2IP_RNW, Bus2IP_Addr,
      output Bus2IP_Data, Bus2IP_BE,
      input  IP2Bus_Data, IP2Bus_RdAck,
      input  IP2Bus_WrAck, IP2Bus_Error
   );

   modport slave (
      input  Bus2IP_CS, Bus2IP_RNW, Bus2IP_Addr,
      input  Bus2IP_Data, Bus2IP_BE,
      output IP2Bus_Data, IP2Bus_RdAck,
      output IP2Bus_WrAck, IP2Bus_Error
   );
endinterface

// File: rtl/nf10_ipif_arbiter.sv
// nf10_ipif_arbiter: round-robin arbiter sharing one IPIF port.
// Optional ack watchdog: define NF10_IPIF_ARB_TIMEOUT_EN.
module nf10_ipif_arbiter #(
   parameter int C_NUM_REQ          = 2,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_TIMEOUT_CYCLES   = 64
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_NUM_REQ-1:0]              REQ_VALID,
   input  logic [C_NUM_REQ-1:0]              REQ_RNW,
   input  logic [C_NUM_REQ*C_S_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [C_NUM_REQ*C_S_AXI_DATA_WIDTH-1:0] REQ_WDATA,
   input  logic [C_NUM_REQ*C_S_AXI_DATA_WIDTH/8-1:0] REQ_BE,
   output logic [C_NUM_REQ-1:0]              REQ_DONE,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     REQ_RDATA,
   output logic                              REQ_ERROR,
   nf10_ipif_arbiter_if.master               ipif
);
   localparam int NR = C_NUM_REQ;
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int BW = DW / 8;
   localparam int GW = $clog2(NR);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP
   } state_t;

   state_t          state_q;
   logic            cs_q;
   logic            rnw_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   data_q;
   logic [BW-1:0]   be_q;
   logic [NR-1:0]   done_q;
   logic [DW-1:0]   rdata_q;
   logic            err_q;
   logic [GW-1:0]   grant_q;
   logic [GW-1:0]   last_q;
   logic [GW-1:0]   grant_d;
   logic            grant_vld;
   logic [NR-1:0]   grant_oh;
   logic            ack_ok;

`ifdef NF10_IPIF_ARB_TIMEOUT_EN
   localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);
   logic [TW-1:0]   wdog_q;
`else
   // Parameter kept so both builds share one parameter list.
   localparam int unused_timeout = C_TIMEOUT_CYCLES;
`endif

   assign grant_oh = NR'(1) << grant_q;
   assign ack_ok   = rnw_q ? ipif.IP2Bus_RdAck
                           : ipif.IP2Bus_WrAck;

   // Round-robin pick: first valid requester after last_q, with wrap.
   always_comb begin
      int k;
      k         = 0;
      grant_vld = 1'b0;
      grant_d   = '0;
      for (int i = NR; i >= 1; i--) begin
         k = (int'(last_q) + i) % NR;
         if (REQ_VALID[k]) begin
            grant_vld = 1'b1;
            grant_d   = GW'(k);
         end
      end
   end

   // Transaction FSM with registered bus and completion outputs.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_q <= S_IDLE;
         cs_q    <= 1'b0;
         rnw_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         be_q    <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         grant_q <= '0;
         last_q  <= GW'(NR - 1);
`ifdef NF10_IPIF_ARB_TIMEOUT_EN
         wdog_q  <= '0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               done_q <= '0;
               if (grant_vld) begin
                  rnw_q   <= REQ_RNW[grant_d];
                  addr_q  <= REQ_ADDR[int'(grant_d)*AW +: AW];
                  data_q  <= REQ_WDATA[int'(grant_d)*DW +: DW];
                  be_q    <= REQ_BE[int'(grant_d)*BW +: BW];
                  cs_q    <= 1'b1;
                  grant_q <= grant_d;
                  last_q  <= grant_d;
                  state_q <= S_ISSUE;
`ifdef NF10_IPIF_ARB_TIMEOUT_EN
                  wdog_q  <= '0;
`endif
               end
            end
            S_ISSUE: begin
               if (ack_ok) begin
                  rdata_q <= rnw_q ? ipif.IP2Bus_Data : '0;
                  err_q   <= ipif.IP2Bus_Error;
                  cs_q    <= 1'b0;
                  done_q  <= grant_oh;
                  state_q <= S_RESP;
               end
`ifdef NF10_IPIF_ARB_TIMEOUT_EN
               else if (wdog_q == TW'(C_TIMEOUT_CYCLES - 1)) begin
                  rdata_q <= DW'(32'hDEADBEEF);
                  err_q   <= 1'b1;
                  cs_q    <= 1'b0;
                  done_q  <= grant_oh;
                  state_q <= S_RESP;
               end else begin
                  wdog_q  <= wdog_q + TW'(1);
               end
`endif
            end
            S_RESP: begin
               done_q  <= '0;
               state_q <= S_IDLE;
            end
            default: begin
               cs_q    <= 1'b0;
               done_q  <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign REQ_DONE         = done_q;
   assign REQ_RDATA        = rdata_q;
   assign REQ_ERROR        = err_q;
   assign ipif.Bus2IP_CS   = cs_q;
   assign ipif.Bus2IP_RNW  = rnw_q;
   assign ipif.Bus2IP_Addr = addr_q;
   assign ipif.Bus2IP_Data = data_q;
   assign ipif.Bus2IP_BE   = be_q;
endmodule

// File: tb/tb_nf10_ipif_arbiter.sv
// tb_nf10_ipif_arbiter: scoreboard bench for the IPIF arbiter.
// Timeout case runs when NF10_IPIF_ARB_TIMEOUT_EN is defined.
module tb_nf10_ipif_arbiter;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BW = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_rnw = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N*BW-1:0] req_be = '0;
   logic [N-1:0]    req_done;
   logic [DW-1:0]   req_rdata;
   logic            req_error;

   nf10_ipif_arbiter_if #(.DW(DW), .AW(AW)) bus ();

   nf10_ipif_arbiter #(
      .C_NUM_REQ(N),
      .C_S_AXI_DATA_WIDTH(DW),
      .C_S_AXI_ADDR_WIDTH(AW),
      .C_TIMEOUT_CYCLES(8)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(rst_n),
      .REQ_VALID(req_valid),
      .REQ_RNW(req_rnw),
      .REQ_ADDR(req_addr),
      .REQ_WDATA(req_wdata),
      .REQ_BE(req_be),
      .REQ_DONE(req_done),
      .REQ_RDATA(req_rdata),
      .REQ_ERROR(req_error),
      .ipif(bus)
   );

   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          start;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int errors = 0;
   int checks = 0;
   int ndone = 0;
   int cyc = 0;
   logic [N-1:0] prev_done = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Slave model knobs, set by the stimulus.
   int          ack_dly = 1;
   logic        ack_err = 1'b0;
   logic        wrong_first = 1'b0;
   logic [31:0] rd_val = '0;
   int          scnt = 0;
   int          cs_cycles = 0;
   logic        stable_bad = 1'b0;
   logic [AW-1:0] cap_addr = '0;
   logic [DW-1:0] cap_data = '0;
   logic [BW-1:0] cap_be = '0;
   logic          cap_rnw = 1'b0;

   // Slave: acks ack_dly cycles after CS, watches bus stability.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.IP2Bus_RdAck <= 1'b0;
         bus.IP2Bus_WrAck <= 1'b0;
         bus.IP2Bus_Error <= 1'b0;
         bus.IP2Bus_Data  <= '0;
         scnt <= 0;
      end else if (bus.Bus2IP_CS) begin
         if (scnt == 0) begin
            cap_addr   <= bus.Bus2IP_Addr;
            cap_data   <= bus.Bus2IP_Data;
            cap_be     <= bus.Bus2IP_BE;
            cap_rnw    <= bus.Bus2IP_RNW;
            stable_bad <= 1'b0;
         end else if ({bus.Bus2IP_Addr, bus.Bus2IP_Data,
                       bus.Bus2IP_BE, bus.Bus2IP_RNW} !==
                      {cap_addr, cap_data, cap_be, cap_rnw}) begin
            stable_bad <= 1'b1;
         end
         if (scnt == ack_dly) begin
            bus.IP2Bus_RdAck <= bus.Bus2IP_RNW;
            bus.IP2Bus_WrAck <= !bus.Bus2IP_RNW;
            bus.IP2Bus_Error <= ack_err;
         end else if (wrong_first && scnt == 0) begin
            bus.IP2Bus_RdAck <= !bus.Bus2IP_RNW;
            bus.IP2Bus_WrAck <= bus.Bus2IP_RNW;
            bus.IP2Bus_Error <= 1'b0;
         end else begin
            bus.IP2Bus_RdAck <= 1'b0;
            bus.IP2Bus_WrAck <= 1'b0;
            bus.IP2Bus_Error <= 1'b0;
         end
         bus.IP2Bus_Data <= rd_val;
         cs_cycles <= scnt + 1;
         scnt <= scnt + 1;
      end else begin
         if (scnt != 0) check("bus_stable", stable_bad, 0);
         bus.IP2Bus_RdAck <= 1'b0;
         bus.IP2Bus_WrAck <= 1'b0;
         bus.IP2Bus_Error <= 1'b0;
         scnt <= 0;
      end
   end

   // Monitor: pops the scoreboard whenever DONE is presented.
   always @(negedge clk) begin
      if (rst_n && req_done != '0) begin
         ndone++;
         check("single_pulse", prev_done, 0);
         if (q.size() == 0) begin
            check("unexpected_done", req_done, 0);
         end else begin
            mon_e = q.pop_front();
            check("done_vec", req_done, N'(1) << mon_e.idx);
            check("rdata", req_rdata, mon_e.rdata);
            check("error", req_error, mon_e.err);
            check("cs_gap", bus.Bus2IP_CS, 0);
            if (mon_e.lat >= 0)
               check("latency", cyc - mon_e.start, mon_e.lat);
         end
      end
      prev_done = req_done;
   end

   task automatic set_req(input int i, input logic rnw,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          input logic [BW-1:0] be);
      req_rnw[i] = rnw;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
      req_be[i*BW +: BW] = be;
   endtask

   task automatic expect_done(input int idx, input logic [31:0] rd,
                              input logic err, input int lat);
      exp_t e;
      e.idx = idx;
      e.rdata = rd;
      e.err = err;
      e.lat = lat;
      e.start = cyc;
      q.push_back(e);
   endtask

   task automatic wait_done(input int target, input int limit);
      int n;
      n = 0;
      while (ndone < target && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_count", ndone, target);
   endtask

   initial begin
      int base;
      #1;
      check("rst_cs", bus.Bus2IP_CS, 0);
      check("rst_done", req_done, 0);
      check("rst_rdata", req_rdata, 0);
      check("rst_error", req_error, 0);
      #21 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single read from requester 0.
      base = ndone;
      ack_dly = 1;
      rd_val = 32'h0000_0A5A;
      set_req(0, 1'b1, 32'h4, 32'h0, 4'hF);
      expect_done(0, 32'h0000_0A5A, 1'b0, 3);
      req_valid[0] = 1'b1;
      wait_done(base + 1, 50);
      req_valid = '0;
      check("rd_addr", cap_addr, 32'h4);
      repeat (2) @(posedge clk);
      #1;

      // Single write from requester 1, slow ack.
      base = ndone;
      ack_dly = 3;
      rd_val = 32'hFFFF_FFFF;
      set_req(1, 1'b0, 32'h20, 32'h1234_5678, 4'hF);
      expect_done(1, 32'h0, 1'b0, 5);
      req_valid[1] = 1'b1;
      wait_done(base + 1, 50);
      req_valid = '0;
      check("wr_data", cap_data, 32'h1234_5678);
      check("wr_be", cap_be, 4'hF);
      check("wr_rnw", cap_rnw, 0);
      check("wr_addr", cap_addr, 32'h20);
      repeat (2) @(posedge clk);
      #1;

      // Contention: both valid for four transactions.
      base = ndone;
      ack_dly = 1;
      rd_val = 32'h0000_0011;
      set_req(0, 1'b1, 32'h8, 32'h0, 4'hF);
      set_req(1, 1'b0, 32'hC, 32'hCAFE_0001, 4'h3);
      expect_done(0, 32'h11, 1'b0, -1);
      expect_done(1, 32'h0, 1'b0, -1);
      expect_done(0, 32'h11, 1'b0, -1);
      expect_done(1, 32'h0, 1'b0, -1);
      req_valid = 2'b11;
      wait_done(base + 4, 100);
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;

      // Wrong-direction ack ignored, then read with error.
      base = ndone;
      ack_dly = 2;
      wrong_first = 1'b1;
      ack_err = 1'b1;
      rd_val = 32'hBEEF_0001;
      set_req(0, 1'b1, 32'h10, 32'h0, 4'hF);
      expect_done(0, 32'hBEEF_0001, 1'b1, 4);
      req_valid[0] = 1'b1;
      wait_done(base + 1, 50);
      req_valid = '0;
      wrong_first = 1'b0;
      ack_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset during ISSUE, then arbitration restarts at req0.
      ack_dly = 1000;
      set_req(1, 1'b1, 32'h30, 32'h0, 4'hF);
      req_valid[1] = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("pre_rst_cs", bus.Bus2IP_CS, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cs", bus.Bus2IP_CS, 0);
      check("mid_rst_done", req_done, 0);
      req_valid = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      base = ndone;
      ack_dly = 1;
      rd_val = 32'h0000_0077;
      set_req(0, 1'b1, 32'h40, 32'h0, 4'hF);
      set_req(1, 1'b0, 32'h44, 32'h5555_AAAA, 4'hF);
      expect_done(0, 32'h77, 1'b0, 3);
      expect_done(1, 32'h0, 1'b0, -1);
      req_valid = 2'b11;
      wait_done(base + 2, 100);
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;

`ifdef NF10_IPIF_ARB_TIMEOUT_EN
      // Slave never acks: watchdog completes with error.
      base = ndone;
      ack_dly = 1000;
      set_req(0, 1'b1, 32'h50, 32'h0, 4'hF);
      expect_done(0, 32'hDEAD_BEEF, 1'b1, 9);
      req_valid[0] = 1'b1;
      wait_done(base + 1, 50);
      req_valid = '0;
      check("to_cs_cycles", cs_cycles, 8);
      ack_dly = 1;
      repeat (2) @(posedge clk);
      #1;
`endif

      repeat (4) @(posedge clk);
      check("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "bench watchdog expired");
   end
endmodule
